operand_stack: RTL

OPERAND_STACK -- requirements
Module: operand_stack

---
 rtl/operand_stack_pkg.sv | 54 +++++
 rtl/operand_stack.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/operand_stack_pkg.sv
// Shared processor package: operand-stack command encodings, ALU op_select
// encodings and small decode helpers used by the stack control logic.
package operand_stack_pkg;

  // Command field width on the stack interface.
  localparam int CMD_W = 3;

  // Stack commands. Code 7 is reserved and executes as a no-op.
  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 3'd0,
    CMD_PUSH  = 3'd1,
    CMD_POP   = 3'd2,
    CMD_BINOP = 3'd3,
    CMD_UNOP  = 3'd4,
    CMD_DUP   = 3'd5,
    CMD_SWAP  = 3'd6,
    CMD_RSVD  = 3'd7
  } stack_cmd_t;

  // ALU op_select width and encodings. The ALU consumes tos/nos and returns
  // alu_result, which BINOP/UNOP write back into the stack.
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SHL  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_NOT  = 4'd7,
    ALU_NEG  = 4'd8,
    ALU_PASS = 4'd9
  } alu_op_t;

  // Minimum number of entries a command needs before it may execute.
  function automatic logic [1:0] cmd_min_count(stack_cmd_t c);
    logic [1:0] need;
    need = 2'd0;
    case (c)
      CMD_POP, CMD_UNOP, CMD_DUP: need = 2'd1;
      CMD_BINOP, CMD_SWAP:        need = 2'd2;
      default:                    need = 2'd0;
    endcase
    return need;
  endfunction

  // True for commands that add an entry and therefore need a free slot.
  function automatic logic cmd_grows(stack_cmd_t c);
    return (c == CMD_PUSH) || (c == CMD_DUP);
  endfunction

endpackage

// File: rtl/operand_stack.sv
// Operand stack feeding the ALU. Entries live in a register array indexed
// by the entry count (stack pointer); tos/nos are read combinationally so
// the ALU sees operands with no added latency. Illegal commands are
// suppressed and latch a sticky error flag until reset.
module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CMD_W-1:0]           cmd,
  input  logic [WIDTH-1:0]           push_data,
  input  logic [WIDTH-1:0]           alu_result,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] TWO   = CW'(2);
  localparam logic [CW-1:0] LIMIT = CW'(DEPTH);

  stack_cmd_t      cmd_dec;
  logic [CW-1:0]   count_reg;
  logic            err_reg;
  logic            illegal;
  logic            exec;

  // Slot indices relative to the pointer. They wrap when the stack is
  // empty or full, but are only used when the command is legal, which
  // guarantees they point inside the valid region.
  logic [AW-1:0]   top_idx;
  logic [AW-1:0]   nos_idx;
  logic [AW-1:0]   new_idx;

  logic [WIDTH-1:0] entries [DEPTH];

  assign cmd_dec = stack_cmd_t'(cmd);
  assign top_idx = AW'(count_reg - ONE);
  assign nos_idx = AW'(count_reg - TWO);
  assign new_idx = AW'(count_reg);

  // Error decode: underflow against the command's operand need, or
  // overflow for commands that add an entry.
  always_comb begin
    illegal = 1'b0;
    if (count_reg < CW'(cmd_min_count(cmd_dec))) begin
      illegal = 1'b1;
    end
    if (cmd_grows(cmd_dec) && (count_reg == LIMIT)) begin
      illegal = 1'b1;
    end
    exec = ~illegal;
  end

  // Stack pointer and sticky error update; reset wins over any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (illegal) begin
      err_reg   <= 1'b1;
    end else begin
      case (cmd_dec)
        CMD_PUSH, CMD_DUP:  count_reg <= count_reg + ONE;
        CMD_POP, CMD_BINOP: count_reg <= count_reg - ONE;
        default:            count_reg <= count_reg;
      endcase
    end
  end

  // Per-slot storage. Each slot decides independently whether this cycle's
  // command targets it, which keeps SWAP (two slots written) and BINOP
  // (result lands in the old NOS slot) straightforward.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      logic             we;
      logic [WIDTH-1:0] wd;
      logic             is_top;
      logic             is_nos;
      logic             is_new;

      assign is_top = (AW'(gi) == top_idx);
      assign is_nos = (AW'(gi) == nos_idx);
      assign is_new = (AW'(gi) == new_idx);

      // Select whether and what this slot captures for the current command.
      always_comb begin
        we = 1'b0;
        wd = entry_reg;
        if (exec) begin
          case (cmd_dec)
            CMD_PUSH: begin
              we = is_new;
              wd = push_data;
            end
            CMD_DUP: begin
              we = is_new;
              wd = tos;
            end
            CMD_UNOP: begin
              we = is_top;
              wd = alu_result;
            end
            CMD_BINOP: begin
              we = is_nos;
              wd = alu_result;
            end
            CMD_SWAP: begin
              we = is_top | is_nos;
              wd = is_top ? nos : tos;
            end
            default: begin
              we = 1'b0;
              wd = entry_reg;
            end
          endcase
        end
      end

      // Slot register; contents need no reset since count hides stale data.
      always_ff @(posedge clk) begin
        if (!rst && we) begin
          entry_reg <= wd;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  // Operand views are masked so stale slots above count never leak out.
  assign tos   = (count_reg == '0) ? '0 : entries[top_idx];
  assign nos   = (count_reg < TWO) ? '0 : entries[nos_idx];
  assign count = count_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == LIMIT);
  assign err   = err_reg;

endmodule
